hsv_core_mem_dport_arbiter: RTL and testbench
=============================================

Name: hsv_core_mem_dport_arbiter

Overview:
- Shares the single data-memory AXI port (dmem_*) between two requesters: requester 0 is the core memory unit (request/response stages), requester 1 is a secondary master such as the debug module.
- Arbitrates the AR channel and the AW+W pair independently.
- Records grant order in per-direction ID FIFOs and routes R/B responses back to the originating requester, in order.
- Sits between the memory unit and the top-level dmem interface.

Parameters:
- DEPTH, 4, max outstanding transactions per direction (read/write ID FIFO depth), power of two >= 2.

Ports:
- clk_core  in  1  core clock
- rst_core_n  in  1  reset; asynchronous, active-low
- req_ar_valid  in  [1:0]  per-requester read address valid
- req_ar_addr  in  [1:0][31:0]  read addresses
- req_ar_ready  out  [1:0]  read address accepted
- req_aw_valid  in  [1:0]  write request valid (address and data presented together)
- req_aw_addr  in  [1:0][31:0]  write addresses
- req_w_data  in  [1:0][31:0]  write data
- req_w_strb  in  [1:0][3:0]  byte strobes
- req_aw_ready  out  [1:0]  write request fully accepted (AW and W both done)
- req_r_valid  out  [1:0]  routed read response valid
- req_r_ready  in  [1:0]  requester read ready
- req_b_valid  out  [1:0]  routed write response valid
- req_b_ready  in  [1:0]  requester write-response ready
- req_r_data  out  32  broadcast read data (qualified by req_r_valid)
- req_r_resp  out  axi_resp_t  broadcast read response
- req_b_resp  out  axi_resp_t  broadcast write response
- dmem_ar_valid/dmem_ar_ready/dmem_ar_addr  out/in/out  1/1/32  shared AR channel
- dmem_aw_valid/dmem_aw_ready/dmem_aw_addr  out/in/out  1/1/32  shared AW channel
- dmem_w_valid/dmem_w_ready/dmem_w_data/dmem_w_strb  out/in/out/out  1/1/32/4  shared W channel
- dmem_r_valid/dmem_r_ready/dmem_r_data/dmem_r_resp  in/out/in/in  1/1/32/axi_resp_t  shared R channel
- dmem_b_valid/dmem_b_ready/dmem_b_resp  in/out/in  1/1/axi_resp_t  shared B channel

Behaviour:
- Reset state:
  - All dmem_*_valid, dmem_*_ready, req_*_ready and req_*_valid are 0.
  - FIFOs are empty.
  - Both round-robin pointers favour requester 0.
- Read grant FSM, states R_IDLE and R_BUSY:
  - In R_IDLE, when any req_ar_valid is set and the read FIFO is not full, grant round-robin starting at the pointer; move to R_BUSY the same cycle (combinational dmem_ar_valid).
  - In R_BUSY, hold the grant and keep dmem_ar_addr stable until dmem_ar_ready.
  - On handshake: push the granted ID, assert req_ar_ready for the granted requester for exactly that cycle, set the pointer to the other requester, return to R_IDLE.
  - Latency from request to dmem_ar_valid is 0 cycles; a new grant is possible the cycle after a handshake.
- Write grant FSM, states W_IDLE, W_BUSY:
  - Grant rule is the same as for reads, using the write FIFO and a separate pointer.
  - In W_BUSY, drive dmem_aw_valid and dmem_w_valid until each has handshaked; aw_done and w_done flags record completion (either order, or the same cycle).
  - When both are done: push the ID, pulse req_aw_ready, clear the flags, update the pointer, return to W_IDLE.
- Full check:
  - Uses the registered count only; a pop in the same cycle does not free a slot for a push in that cycle.
  - count == DEPTH blocks new grants only; an in-flight grant always completes.
- Response routing:
  - req_r_valid[head] = dmem_r_valid when the read FIFO is non-empty; dmem_r_ready = req_r_ready[head].
  - Pop on dmem_r_valid & dmem_r_ready.
  - B channel is identical, using the write FIFO.
  - Empty FIFO: dmem_r_ready = dmem_b_ready = 0 and nothing is routed (protocol violation, covered by assertion).
- Simultaneous push and pop on one FIFO: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH; count width is $clog2(DEPTH+1).
- No flush input: outstanding responses always drain to their requester. The memory unit's own counters handle discard.
- Reset mid-transaction: all state is cleared immediately; the external memory is reset by the same domain.

Decomposition:
- hsv_core_pkg gains:
  - dport_id_t (1-bit requester ID)
  - constant DPORT_REQUESTERS = 2
  - reuse of the existing axi_resp_t and word
- One sub-module, hsv_core_mem_id_fifo (parameterized DEPTH; push/pop/full/empty/head), instantiated twice.

Test Plan:
- Single read, requester 0: ar_valid=1 addr 0x100, ar_ready after 2 cycles, R data 0xDEADBEEF OKAY -> req_ar_ready[0] pulses once, req_r_valid[0]=1 with 0xDEADBEEF, req_r_valid[1]=0.
- Contention: both requesters hold ar_valid with dmem_ar_ready=1 -> grants alternate 0,1,0,1; R responses route in that order.
- Back-pressure: dmem_ar_ready=0 for 5 cycles with requester 1 raising valid meanwhile -> dmem_ar_addr stays at requester 0's address and the grant does not switch.
- Write split handshake: W accepted at cycle 1, AW at cycle 3 -> req_aw_ready pulses at cycle 3 only; B with SLVERR routes to the correct requester with req_b_resp=SLVERR.
- Full: DEPTH=4 reads outstanding with no R -> 5th request sees dmem_ar_valid=0. Pop one R -> the 5th is granted the following cycle, not the same cycle.
- Async reset asserted while W_BUSY with aw_done=1 -> all valids drop immediately, FIFOs empty, and pointers favour requester 0 after release.

Source files
------------

// File: rtl/hsv_core_pkg.sv
// Shared core types: AXI response codes, data-port requester IDs and arbiter FSM states.
package hsv_core_pkg;

    typedef logic [31:0] word;

    typedef enum logic [1:0] {
        AXI_OKAY   = 2'b00,
        AXI_EXOKAY = 2'b01,
        AXI_SLVERR = 2'b10,
        AXI_DECERR = 2'b11
    } axi_resp_t;

    typedef logic dport_id_t;

    localparam int DPORT_REQUESTERS = 2;

    typedef enum logic {R_IDLE, R_BUSY} dport_rd_state_t;
    typedef enum logic {W_IDLE, W_BUSY} dport_wr_state_t;

    // Round-robin pick: the pointer's requester wins if it is asking, otherwise the other one.
    function automatic dport_id_t dport_rr_pick(input logic [DPORT_REQUESTERS-1:0] valid,
                                                input dport_id_t ptr);
        return valid[ptr] ? ptr : ~ptr;
    endfunction

endpackage

// File: rtl/hsv_core_mem_id_fifo.sv
// In-order record of which requester owns each outstanding transaction.
module hsv_core_mem_id_fifo
    import hsv_core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_core,
    input  logic      rst_core_n,
    input  logic      push_i,
    input  dport_id_t push_id_i,
    input  logic      pop_i,
    output logic      full_o,
    output logic      empty_o,
    output dport_id_t head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    dport_id_t        mem_q [DEPTH];

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_i && !pop_i)      count_q <= count_q + CNT_W'(1);
            else if (pop_i && !push_i) count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_core) begin
        if (push_i) mem_q[wr_ptr_q] <= push_id_i;
    end

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/hsv_core_mem_dport_arbiter.sv
// Two-requester arbiter for the shared dmem AXI port; responses return to their owner in order.
module hsv_core_mem_dport_arbiter
    import hsv_core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                             clk_core,
    input  logic                             rst_core_n,
    input  logic [DPORT_REQUESTERS-1:0]      req_ar_valid,
    input  logic [DPORT_REQUESTERS-1:0][31:0] req_ar_addr,
    output logic [DPORT_REQUESTERS-1:0]      req_ar_ready,
    input  logic [DPORT_REQUESTERS-1:0]      req_aw_valid,
    input  logic [DPORT_REQUESTERS-1:0][31:0] req_aw_addr,
    input  logic [DPORT_REQUESTERS-1:0][31:0] req_w_data,
    input  logic [DPORT_REQUESTERS-1:0][3:0] req_w_strb,
    output logic [DPORT_REQUESTERS-1:0]      req_aw_ready,
    output logic [DPORT_REQUESTERS-1:0]      req_r_valid,
    input  logic [DPORT_REQUESTERS-1:0]      req_r_ready,
    output logic [DPORT_REQUESTERS-1:0]      req_b_valid,
    input  logic [DPORT_REQUESTERS-1:0]      req_b_ready,
    output logic [31:0]                      req_r_data,
    output axi_resp_t                        req_r_resp,
    output axi_resp_t                        req_b_resp,
    output logic                             dmem_ar_valid,
    input  logic                             dmem_ar_ready,
    output logic [31:0]                      dmem_ar_addr,
    output logic                             dmem_aw_valid,
    input  logic                             dmem_aw_ready,
    output logic [31:0]                      dmem_aw_addr,
    output logic                             dmem_w_valid,
    input  logic                             dmem_w_ready,
    output logic [31:0]                      dmem_w_data,
    output logic [3:0]                       dmem_w_strb,
    input  logic                             dmem_r_valid,
    output logic                             dmem_r_ready,
    input  logic [31:0]                      dmem_r_data,
    input  axi_resp_t                        dmem_r_resp,
    input  logic                             dmem_b_valid,
    output logic                             dmem_b_ready,
    input  axi_resp_t                        dmem_b_resp
);

    dport_rd_state_t rstate_q, rstate_d;
    dport_wr_state_t wstate_q, wstate_d;
    dport_id_t       rgnt_q, rgnt_d, rptr_q, rptr_d, ar_id;
    dport_id_t       wgnt_q, wgnt_d, wptr_q, wptr_d, wr_id;
    logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic            aw_fin, w_fin, w_active;
    logic            rpush, rpop, rfull, rempty;
    logic            wpush, wpop, wfull, wempty;
    dport_id_t       rhead, bhead;

    // Read grant: dmem_ar_valid rises in the same cycle as the request; the grant then holds.
    always_comb begin
        rstate_d      = rstate_q;
        rgnt_d        = rgnt_q;
        rptr_d        = rptr_q;
        ar_id         = rgnt_q;
        dmem_ar_valid = 1'b0;
        rpush         = 1'b0;
        req_ar_ready  = '0;
        case (rstate_q)
            R_IDLE: if (rst_core_n && |req_ar_valid && !rfull) begin
                ar_id         = dport_rr_pick(req_ar_valid, rptr_q);
                rgnt_d        = ar_id;
                dmem_ar_valid = 1'b1;
                rstate_d      = R_BUSY;
            end
            R_BUSY:  dmem_ar_valid = 1'b1;
            default: rstate_d = R_IDLE;
        endcase
        if (dmem_ar_valid && dmem_ar_ready) begin
            rpush               = 1'b1;
            req_ar_ready[ar_id] = 1'b1;
            rptr_d              = ~ar_id;
            rstate_d            = R_IDLE;
        end
    end

    assign dmem_ar_addr = req_ar_addr[ar_id];

    // Write grant: AW and W complete independently; the done flags remember whichever finished first.
    always_comb begin
        wstate_d      = wstate_q;
        wgnt_d        = wgnt_q;
        wptr_d        = wptr_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        wr_id         = wgnt_q;
        dmem_aw_valid = 1'b0;
        dmem_w_valid  = 1'b0;
        wpush         = 1'b0;
        w_active      = 1'b0;
        req_aw_ready  = '0;
        case (wstate_q)
            W_IDLE: if (rst_core_n && |req_aw_valid && !wfull) begin
                wr_id         = dport_rr_pick(req_aw_valid, wptr_q);
                wgnt_d        = wr_id;
                dmem_aw_valid = 1'b1;
                dmem_w_valid  = 1'b1;
                w_active      = 1'b1;
                wstate_d      = W_BUSY;
            end
            W_BUSY: begin
                dmem_aw_valid = !aw_done_q;
                dmem_w_valid  = !w_done_q;
                w_active      = 1'b1;
            end
            default: wstate_d = W_IDLE;
        endcase
        aw_fin = aw_done_q | (dmem_aw_valid & dmem_aw_ready);
        w_fin  = w_done_q | (dmem_w_valid & dmem_w_ready);
        if (w_active) begin
            if (aw_fin && w_fin) begin
                wpush               = 1'b1;
                req_aw_ready[wr_id] = 1'b1;
                wptr_d              = ~wr_id;
                wstate_d            = W_IDLE;
                aw_done_d           = 1'b0;
                w_done_d            = 1'b0;
            end else begin
                aw_done_d = aw_fin;
                w_done_d  = w_fin;
            end
        end
    end

    assign dmem_aw_addr = req_aw_addr[wr_id];
    assign dmem_w_data  = req_w_data[wr_id];
    assign dmem_w_strb  = req_w_strb[wr_id];

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            rstate_q  <= R_IDLE;
            rgnt_q    <= 1'b0;
            rptr_q    <= 1'b0;
            wstate_q  <= W_IDLE;
            wgnt_q    <= 1'b0;
            wptr_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            rstate_q  <= rstate_d;
            rgnt_q    <= rgnt_d;
            rptr_q    <= rptr_d;
            wstate_q  <= wstate_d;
            wgnt_q    <= wgnt_d;
            wptr_q    <= wptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Responses go to the FIFO head; with nothing outstanding the dmem side sees no ready.
    always_comb begin
        req_r_valid = '0;
        req_b_valid = '0;
        if (!rempty) req_r_valid[rhead] = dmem_r_valid;
        if (!wempty) req_b_valid[bhead] = dmem_b_valid;
    end

    assign dmem_r_ready = !rempty && req_r_ready[rhead];
    assign dmem_b_ready = !wempty && req_b_ready[bhead];
    assign rpop         = dmem_r_valid && dmem_r_ready;
    assign wpop         = dmem_b_valid && dmem_b_ready;
    assign req_r_data   = dmem_r_data;
    assign req_r_resp   = dmem_r_resp;
    assign req_b_resp   = dmem_b_resp;

    hsv_core_mem_id_fifo #(.DEPTH(DEPTH)) u_rd_fifo (
        .clk_core  (clk_core),
        .rst_core_n(rst_core_n),
        .push_i    (rpush),
        .push_id_i (ar_id),
        .pop_i     (rpop),
        .full_o    (rfull),
        .empty_o   (rempty),
        .head_o    (rhead)
    );

    hsv_core_mem_id_fifo #(.DEPTH(DEPTH)) u_wr_fifo (
        .clk_core  (clk_core),
        .rst_core_n(rst_core_n),
        .push_i    (wpush),
        .push_id_i (wr_id),
        .pop_i     (wpop),
        .full_o    (wfull),
        .empty_o   (wempty),
        .head_o    (bhead)
    );

    a_r_orphan: assert property (@(posedge clk_core) disable iff (!rst_core_n)
                                 dmem_r_valid |-> !rempty);
    a_b_orphan: assert property (@(posedge clk_core) disable iff (!rst_core_n)
                                 dmem_b_valid |-> !wempty);

endmodule

// File: tb/tb_hsv_core_mem_dport_arbiter.sv
// Directed bench for the dmem data-port arbiter.
module tb_hsv_core_mem_dport_arbiter;
    import hsv_core_pkg::*;

    logic             clk_core = 1'b0;
    logic             rst_core_n;
    logic [1:0]       req_ar_valid, req_ar_ready, req_aw_valid, req_aw_ready;
    logic [1:0][31:0] req_ar_addr, req_aw_addr, req_w_data;
    logic [1:0][3:0]  req_w_strb;
    logic [1:0]       req_r_valid, req_r_ready, req_b_valid, req_b_ready;
    logic [31:0]      req_r_data;
    axi_resp_t        req_r_resp, req_b_resp;
    logic             dmem_ar_valid, dmem_ar_ready, dmem_aw_valid, dmem_aw_ready;
    logic             dmem_w_valid, dmem_w_ready, dmem_r_valid, dmem_r_ready;
    logic             dmem_b_valid, dmem_b_ready;
    logic [31:0]      dmem_ar_addr, dmem_aw_addr, dmem_w_data, dmem_r_data;
    logic [3:0]       dmem_w_strb;
    axi_resp_t        dmem_r_resp, dmem_b_resp;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_core = ~clk_core;

    hsv_core_mem_dport_arbiter #(.DEPTH(4)) dut (
        .clk_core(clk_core), .rst_core_n(rst_core_n),
        .req_ar_valid(req_ar_valid), .req_ar_addr(req_ar_addr), .req_ar_ready(req_ar_ready),
        .req_aw_valid(req_aw_valid), .req_aw_addr(req_aw_addr), .req_w_data(req_w_data),
        .req_w_strb(req_w_strb), .req_aw_ready(req_aw_ready),
        .req_r_valid(req_r_valid), .req_r_ready(req_r_ready),
        .req_b_valid(req_b_valid), .req_b_ready(req_b_ready),
        .req_r_data(req_r_data), .req_r_resp(req_r_resp), .req_b_resp(req_b_resp),
        .dmem_ar_valid(dmem_ar_valid), .dmem_ar_ready(dmem_ar_ready), .dmem_ar_addr(dmem_ar_addr),
        .dmem_aw_valid(dmem_aw_valid), .dmem_aw_ready(dmem_aw_ready), .dmem_aw_addr(dmem_aw_addr),
        .dmem_w_valid(dmem_w_valid), .dmem_w_ready(dmem_w_ready), .dmem_w_data(dmem_w_data),
        .dmem_w_strb(dmem_w_strb),
        .dmem_r_valid(dmem_r_valid), .dmem_r_ready(dmem_r_ready), .dmem_r_data(dmem_r_data),
        .dmem_r_resp(dmem_r_resp),
        .dmem_b_valid(dmem_b_valid), .dmem_b_ready(dmem_b_ready), .dmem_b_resp(dmem_b_resp)
    );

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(negedge clk_core);
    endtask

    task automatic idle_inputs();
        req_ar_valid = '0; req_aw_valid = '0; req_r_ready = 2'b11; req_b_ready = 2'b11;
        dmem_ar_ready = 0; dmem_aw_ready = 0; dmem_w_ready = 0;
        dmem_r_valid = 0; dmem_b_valid = 0;
        dmem_r_data = '0; dmem_r_resp = AXI_OKAY; dmem_b_resp = AXI_OKAY;
    endtask

    task automatic test_reset();
        logic [12:0] outs;
        rst_core_n = 0;
        idle_inputs();
        req_ar_addr = '0; req_aw_addr = '0; req_w_data = '0; req_w_strb = '0;
        req_ar_valid = 2'b11;
        req_aw_valid = 2'b11;
        tick(); tick();
        #1;
        outs = {dmem_ar_valid, dmem_aw_valid, dmem_w_valid, dmem_r_ready, dmem_b_ready,
                req_ar_ready, req_aw_ready, req_r_valid, req_b_valid};
        n_chk++;
        if (outs !== 13'd0) $display("FAIL reset_outputs: got %b want 0", outs);
        else n_pass++;
        idle_inputs();
        tick();
        rst_core_n = 1;
        tick();
    endtask

    task automatic test_contention();
        dport_id_t exp_id;
        req_ar_addr[0] = 32'h200; req_ar_addr[1] = 32'h300;
        req_ar_valid = 2'b11; dmem_ar_ready = 1;
        for (int k = 0; k < 4; k++) begin
            exp_id = dport_id_t'(k % 2);
            #1;
            n_chk++;
            if (req_ar_ready !== (2'b01 << exp_id) || dmem_ar_addr !== (exp_id ? 32'h300 : 32'h200))
                $display("FAIL contention_grant%0d: ready %b addr %h want id %0d", k, req_ar_ready, dmem_ar_addr, exp_id);
            else n_pass++;
            tick();
        end
        req_ar_valid = '0; dmem_ar_ready = 0;
        for (int k = 0; k < 4; k++) begin
            dmem_r_valid = 1; dmem_r_data = 32'hA000_0000 + k;
            exp_id = dport_id_t'(k % 2);
            #1;
            n_chk++;
            if (req_r_valid !== (2'b01 << exp_id) || req_r_data !== 32'hA000_0000 + k || dmem_r_ready !== 1'b1)
                $display("FAIL contention_route%0d: r_valid %b data %h want id %0d", k, req_r_valid, req_r_data, exp_id);
            else n_pass++;
            tick();
        end
        dmem_r_valid = 0;
        #1;
        n_chk++;
        if (dmem_r_ready !== 1'b0) $display("FAIL contention_drained: dmem_r_ready %b want 0", dmem_r_ready);
        else n_pass++;
        tick();
    endtask

    task automatic test_single_read();
        int pulses = 0;
        req_ar_valid = 2'b01; req_ar_addr[0] = 32'h100;
        for (int c = 0; c < 3; c++) begin
            dmem_ar_ready = (c == 2);
            #1;
            n_chk++;
            if (dmem_ar_valid !== 1'b1 || dmem_ar_addr !== 32'h100)
                $display("FAIL single_ar%0d: valid %b addr %h want 1 00000100", c, dmem_ar_valid, dmem_ar_addr);
            else n_pass++;
            pulses += int'(req_ar_ready[0]);
            tick();
        end
        req_ar_valid = '0; dmem_ar_ready = 0;
        #1;
        pulses += int'(req_ar_ready[0]);
        n_chk++;
        if (pulses != 1 || dmem_ar_valid !== 1'b0)
            $display("FAIL single_ready_pulse: pulses %0d ar_valid %b want 1 0", pulses, dmem_ar_valid);
        else n_pass++;
        dmem_r_valid = 1; dmem_r_data = 32'hDEADBEEF; dmem_r_resp = AXI_OKAY;
        #1;
        n_chk++;
        if (req_r_valid !== 2'b01 || req_r_data !== 32'hDEADBEEF || req_r_resp !== AXI_OKAY)
            $display("FAIL single_r_route: r_valid %b data %h resp %0d want 01 deadbeef 0", req_r_valid, req_r_data, req_r_resp);
        else n_pass++;
        tick();
        dmem_r_valid = 0;
        tick();
    endtask

    task automatic test_backpressure();
        req_ar_valid = 2'b01; req_ar_addr[0] = 32'h400; req_ar_addr[1] = 32'h500;
        dmem_ar_ready = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) req_ar_valid = 2'b11;
            #1;
            n_chk++;
            if (dmem_ar_addr !== 32'h400 || req_ar_ready !== 2'b00 || dmem_ar_valid !== 1'b1)
                $display("FAIL backpressure_hold%0d: addr %h ready %b want 00000400 00", c, dmem_ar_addr, req_ar_ready);
            else n_pass++;
            tick();
        end
        dmem_ar_ready = 1;
        #1;
        n_chk++;
        if (req_ar_ready !== 2'b01 || dmem_ar_addr !== 32'h400)
            $display("FAIL backpressure_accept0: ready %b addr %h want 01 00000400", req_ar_ready, dmem_ar_addr);
        else n_pass++;
        tick();
        req_ar_valid = 2'b10;
        #1;
        n_chk++;
        if (req_ar_ready !== 2'b10 || dmem_ar_addr !== 32'h500)
            $display("FAIL backpressure_accept1: ready %b addr %h want 10 00000500", req_ar_ready, dmem_ar_addr);
        else n_pass++;
        tick();
        req_ar_valid = '0; dmem_ar_ready = 0;
        for (int k = 0; k < 2; k++) begin
            dmem_r_valid = 1;
            #1;
            n_chk++;
            if (req_r_valid !== (k == 0 ? 2'b01 : 2'b10))
                $display("FAIL backpressure_route%0d: r_valid %b want %b", k, req_r_valid, (k == 0 ? 2'b01 : 2'b10));
            else n_pass++;
            tick();
        end
        dmem_r_valid = 0;
        tick();
    endtask

    task automatic test_write_split();
        req_aw_valid = 2'b10; req_aw_addr[1] = 32'h600;
        req_w_data[1] = 32'hCAFEF00D; req_w_strb[1] = 4'hF;
        for (int c = 0; c < 4; c++) begin
            dmem_w_ready  = (c == 1);
            dmem_aw_ready = (c == 3);
            #1;
            n_chk++;
            if (dmem_aw_valid !== 1'b1 || dmem_w_valid !== (c <= 1) ||
                req_aw_ready !== (c == 3 ? 2'b10 : 2'b00) ||
                dmem_aw_addr !== 32'h600 || (c <= 1 && (dmem_w_data !== 32'hCAFEF00D || dmem_w_strb !== 4'hF)))
                $display("FAIL write_split%0d: aw_v %b w_v %b aw_rdy %b addr %h data %h", c,
                         dmem_aw_valid, dmem_w_valid, req_aw_ready, dmem_aw_addr, dmem_w_data);
            else n_pass++;
            tick();
        end
        req_aw_valid = '0; dmem_aw_ready = 0; dmem_w_ready = 0;
        #1;
        n_chk++;
        if (dmem_aw_valid !== 1'b0 || dmem_w_valid !== 1'b0 || req_aw_ready !== 2'b00)
            $display("FAIL write_idle: aw_v %b w_v %b rdy %b want 0 0 00", dmem_aw_valid, dmem_w_valid, req_aw_ready);
        else n_pass++;
        dmem_b_valid = 1; dmem_b_resp = AXI_SLVERR;
        #1;
        n_chk++;
        if (req_b_valid !== 2'b10 || req_b_resp !== AXI_SLVERR || dmem_b_ready !== 1'b1)
            $display("FAIL write_b_route: b_valid %b resp %0d want 10 2", req_b_valid, req_b_resp);
        else n_pass++;
        tick();
        dmem_b_valid = 0; dmem_b_resp = AXI_OKAY;
        tick();
    endtask

    task automatic test_full();
        req_ar_valid = 2'b01; dmem_ar_ready = 1;
        for (int k = 0; k < 4; k++) begin
            req_ar_addr[0] = 32'h1000 + 32'(k * 4);
            tick();
        end
        req_ar_addr[0] = 32'h1010;
        #1;
        n_chk++;
        if (dmem_ar_valid !== 1'b0 || req_ar_ready !== 2'b00)
            $display("FAIL full_blocks: ar_valid %b ready %b want 0 00", dmem_ar_valid, req_ar_ready);
        else n_pass++;
        tick();
        dmem_r_valid = 1;
        #1;
        n_chk++;
        if (dmem_ar_valid !== 1'b0 || dmem_r_ready !== 1'b1)
            $display("FAIL full_same_cycle_pop: ar_valid %b r_ready %b want 0 1", dmem_ar_valid, dmem_r_ready);
        else n_pass++;
        tick();
        dmem_r_valid = 0;
        #1;
        n_chk++;
        if (dmem_ar_valid !== 1'b1 || req_ar_ready !== 2'b01 || dmem_ar_addr !== 32'h1010)
            $display("FAIL full_next_grant: ar_valid %b ready %b addr %h want 1 01 00001010", dmem_ar_valid, req_ar_ready, dmem_ar_addr);
        else n_pass++;
        tick();
        req_ar_valid = '0; dmem_ar_ready = 0;
        for (int k = 0; k < 4; k++) begin
            dmem_r_valid = 1;
            #1;
            n_chk++;
            if (req_r_valid !== 2'b01) $display("FAIL full_drain%0d: r_valid %b want 01", k, req_r_valid);
            else n_pass++;
            tick();
        end
        dmem_r_valid = 0;
        tick();
    endtask

    task automatic test_reset_mid_write();
        logic [12:0] outs;
        req_aw_valid = 2'b01; req_aw_addr[0] = 32'h900; req_w_data[0] = 32'h1234_5678; req_w_strb[0] = 4'h3;
        dmem_aw_ready = 1; dmem_w_ready = 0;
        req_ar_valid = 2'b01; req_ar_addr[0] = 32'hA00; dmem_ar_ready = 1;
        tick();
        dmem_aw_ready = 0; req_ar_valid = '0; dmem_ar_ready = 0;
        #1;
        n_chk++;
        if (dmem_aw_valid !== 1'b0 || dmem_w_valid !== 1'b1 || dmem_r_ready !== 1'b1)
            $display("FAIL midwrite_state: aw_v %b w_v %b r_rdy %b want 0 1 1", dmem_aw_valid, dmem_w_valid, dmem_r_ready);
        else n_pass++;
        #1;
        rst_core_n = 0;
        #1;
        outs = {dmem_ar_valid, dmem_aw_valid, dmem_w_valid, dmem_r_ready, dmem_b_ready,
                req_ar_ready, req_aw_ready, req_r_valid, req_b_valid};
        n_chk++;
        if (outs !== 13'd0) $display("FAIL midwrite_async_reset: outputs %b want 0", outs);
        else n_pass++;
        req_aw_valid = '0;
        tick(); tick();
        rst_core_n = 1;
        #1;
        n_chk++;
        if (dmem_r_ready !== 1'b0 || dmem_b_ready !== 1'b0 || dmem_w_valid !== 1'b0)
            $display("FAIL midwrite_fifos_empty: r_rdy %b b_rdy %b w_v %b want 0 0 0", dmem_r_ready, dmem_b_ready, dmem_w_valid);
        else n_pass++;
        tick();
        req_ar_valid = 2'b11; req_ar_addr[0] = 32'h700; req_ar_addr[1] = 32'h800; dmem_ar_ready = 1;
        req_aw_valid = 2'b11; req_aw_addr[0] = 32'hB00; req_aw_addr[1] = 32'hC00;
        #1;
        n_chk++;
        if (req_ar_ready !== 2'b01 || dmem_ar_addr !== 32'h700 || dmem_aw_addr !== 32'hB00)
            $display("FAIL midwrite_ptr_reset: ar_rdy %b ar %h aw %h want 01 00000700 00000b00", req_ar_ready, dmem_ar_addr, dmem_aw_addr);
        else n_pass++;
        tick();
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_read();
        test_backpressure();
        test_write_split();
        test_full();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
